// File: rtl/pin_bus_pkg.sv
// Shared definitions for the 8-bit address/data pin bus: field widths,
// responder FSM states and the default output-register address.
package pin_bus_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] IO_ADDR_DEFAULT = 8'hFF;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage : pin_bus_pkg

// File: rtl/pin_bus_responder_if.sv
// Request/response handshake signals of the pin bus; the initiator drives the
// master modport, the responder uses the slave modport.
interface pin_bus_responder_if;
  import pin_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface : pin_bus_responder_if

// File: rtl/pin_bus_mem.sv
// Byte memory for the pin bus responder: synchronous write, combinational
// read, contents deliberately left unreset.
module pin_bus_mem
  import pin_bus_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned AW        = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : pin_bus_mem

// File: rtl/pin_bus_responder.sv
// Target-side pin bus responder: decodes requests onto a local byte memory or
// the output register and answers after a fixed number of wait states.
module pin_bus_responder
  import pin_bus_pkg::*;
#(
  parameter int unsigned       MEM_DEPTH   = 64,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  pin_bus_responder_if.slave bus,
  output logic [DATA_W-1:0]  io_out
);

  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_e                  state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    we_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic [DATA_W-1:0]       rsp_rdata_q;
  logic                    rsp_err_q;
  logic [DATA_W-1:0]       io_q;

  logic [ADDR_W-1:0]       dec_addr;
  logic                    dec_we;
  logic                    hit_mem;
  logic                    hit_io;
  logic [DATA_W-1:0]       mem_rdata;
  logic [DATA_W-1:0]       rsp_rdata_d;
  logic                    rsp_err_d;
  logic                    accept;
  logic                    mem_we;

  // In IDLE the live request is decoded (write commit, zero-wait capture);
  // afterwards the latched request is decoded for the deferred read capture.
  always_comb begin
    dec_addr    = (state_q == ST_IDLE) ? bus.req_addr : addr_q;
    dec_we      = (state_q == ST_IDLE) ? bus.req_we   : we_q;
    hit_mem     = ({1'b0, dec_addr} < MEM_LIMIT);
    hit_io      = !hit_mem && (dec_addr == IO_ADDR);
    rsp_err_d   = !(hit_mem || hit_io);
    rsp_rdata_d = '0;
    if (!dec_we) begin
      if (hit_mem) begin
        rsp_rdata_d = mem_rdata;
      end else if (hit_io) begin
        rsp_rdata_d = io_q;
      end
    end
  end

  assign accept = (state_q == ST_IDLE) && bus.req_valid;
  assign mem_we = accept && bus.req_we && hit_mem;

  pin_bus_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (MEM_AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (bus.req_addr[MEM_AW-1:0]),
    .wdata_i (bus.req_wdata),
    .raddr_i (dec_addr[MEM_AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      io_q        <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q      <= bus.req_addr;
            we_q        <= bus.req_we;
            req_ready_q <= 1'b0;
            if (bus.req_we && hit_io) begin
              io_q <= bus.req_wdata;
            end
            if (WAIT_STATES == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign io_out        = io_q;

endmodule : pin_bus_responder
